// File: rtl/bringup_pkg.sv
// Shared definitions for the bringup sensor scanner: FSM encoding and
// the layout of one {channel, level} event word.
package bringup_pkg;

    // Scanner control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } scan_state_e;

    // Event word layout: level in the LSB, channel index above it
    localparam int EV_LEVEL_BIT = 0;
    localparam int EV_CH_LSB    = 1;

    // Width of an event word for a given channel-index width
    function automatic int ev_width(input int ch_bits);
        return ch_bits + 1;
    endfunction

endpackage

// File: rtl/bringup_event_fifo.sv
// Small synchronous event FIFO. Storage is registered; read and write
// pointers carry one extra wrap bit so full and empty can be told apart.
// A push is accepted when there is room after the same-cycle pop, so a
// full FIFO can take a push and a pop together. While empty, pop_data
// keeps presenting the most recently popped word.
module bringup_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head word, or the last popped word once the FIFO has drained
    assign pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

    // Pointer update; both may advance in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Event storage, written at the write pointer
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Remember the word leaving the FIFO so the outputs hold when empty
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= '0;
        end else if (do_pop) begin
            last_q <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/bringup_sensor_scanner.sv
// Controller for a bank of bringup sensors. Generates the shared decay
// strobe, scans the sensed levels round-robin and reports every level
// change as a {channel, level} event through a small FIFO. If the FIFO
// is full the scan parks on the changed channel and retries, so no
// change is dropped; the sticky stall flag records that this happened.
module bringup_sensor_scanner
    import bringup_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int CH_BITS    = $clog2(CHANNELS),
    parameter int DEC_PERIOD = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable_i,
    output logic                dec_o,
    input  logic [CHANNELS-1:0] sensed_i,
    output logic                ev_valid_o,
    input  logic                ev_ready_i,
    output logic [CH_BITS-1:0]  ev_channel_o,
    output logic                ev_level_o,
    output logic                stall_o,
    output logic [CHANNELS-1:0] state_o
);

    localparam int                EV_W     = ev_width(CH_BITS);
    localparam int                PW       = $clog2(DEC_PERIOD);
    localparam logic [PW-1:0]     PRE_LAST = PW'(DEC_PERIOD - 1);
    localparam logic [CH_BITS-1:0] IDX_LAST = CH_BITS'(CHANNELS - 1);

    scan_state_e        state_q;
    scan_state_e        state_d;
    logic [PW-1:0]      pre_cnt;
    logic [CH_BITS-1:0] scan_idx;

    logic               in_sync;
    logic               in_run;
    logic               cur_bit;
    logic               differ;
    logic               can_push;
    logic               ev_push;
    logic               advance;
    logic               stall_hit;

    logic [EV_W-1:0]    ev_data;
    logic [EV_W-1:0]    head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    // Decay prescaler: strobe follows the cycle in which the count wraps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            dec_o   <= 1'b0;
        end else if (!enable_i) begin
            pre_cnt <= '0;
            dec_o   <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            dec_o   <= (pre_cnt == PRE_LAST);
        end
    end

    // Scanner state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle scan decisions
    always_comb begin
        state_d   = state_q;
        in_sync   = 1'b0;
        in_run    = 1'b0;
        cur_bit   = sensed_i[scan_idx];
        differ    = 1'b0;
        can_push  = !fifo_full || fifo_pop;
        ev_push   = 1'b0;
        advance   = 1'b0;
        stall_hit = 1'b0;
        case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
                in_sync = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                in_run    = 1'b1;
                differ    = (cur_bit != state_o[scan_idx]);
                ev_push   = differ && can_push;
                advance   = !differ || can_push;
                stall_hit = differ && !can_push;
                state_d   = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i) begin
            state_d = IDLE;
        end
    end

    // Scan index: restarts on sync, parks while a change cannot be queued
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx <= '0;
        end else if (in_sync) begin
            scan_idx <= '0;
        end else if (in_run && advance) begin
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end
    end

    // Last reported level per channel; sync adopts the live levels silently
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_o <= '0;
        end else if (in_sync) begin
            state_o <= sensed_i;
        end else if (ev_push) begin
            state_o[scan_idx] <= cur_bit;
        end
    end

    // Sticky record of any scan stall on a full FIFO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_o <= 1'b0;
        end else if (stall_hit) begin
            stall_o <= 1'b1;
        end
    end

    assign ev_data  = {scan_idx, cur_bit};
    assign fifo_pop = ev_valid_o && ev_ready_i;

    bringup_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ev_push),
        .push_data (ev_data),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (head_data),
        .empty     (fifo_empty)
    );

    assign ev_valid_o   = !fifo_empty;
    assign ev_channel_o = head_data[EV_W-1:EV_CH_LSB];
    assign ev_level_o   = head_data[EV_LEVEL_BIT];

endmodule

// File: tb/tb_bringup_sensor_scanner.sv
// Self-checking bench for bringup_sensor_scanner: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_bringup_sensor_scanner;

    localparam int CH = 8;
    localparam int CB = 3;
    localparam int DP = 8;
    localparam int FD = 4;

    logic          clock;
    logic          reset_n;
    logic          enable_i;
    logic          dec_o;
    logic [CH-1:0] sensed_i;
    logic          ev_valid_o;
    logic          ev_ready_i;
    logic [CB-1:0] ev_channel_o;
    logic          ev_level_o;
    logic          stall_o;
    logic [CH-1:0] state_o;

    bringup_sensor_scanner #(
        .CHANNELS   (CH),
        .CH_BITS    (CB),
        .DEC_PERIOD (DP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable_i     (enable_i),
        .dec_o        (dec_o),
        .sensed_i     (sensed_i),
        .ev_valid_o   (ev_valid_o),
        .ev_ready_i   (ev_ready_i),
        .ev_channel_o (ev_channel_o),
        .ev_level_o   (ev_level_o),
        .stall_o      (stall_o),
        .state_o      (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: events are channel*2+level in a plain queue
    int            q[$];
    int            last_ev;
    logic [CH-1:0] m_lvl;
    int            m_idx;
    int            m_mode;   // 0 idle, 1 sync pending, 2 scanning
    bit            m_stall;
    int            en_cnt;
    bit            m_dec;
    int            dut_log[$];

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_ev = 0;
        m_lvl   = '0;
        m_idx   = 0;
        m_mode  = 0;
        m_stall = 0;
        en_cnt  = 0;
        m_dec   = 0;
    endtask

    task automatic model_step();
        bit pop;
        bit room;
        int b;
        pop = (q.size() > 0) && ev_ready_i;
        if (pop) last_ev = q.pop_front();
        room = (q.size() < FD);
        if (m_mode == 1) begin
            m_lvl = sensed_i;
            m_idx = 0;
        end else if (m_mode == 2) begin
            b = int'(sensed_i[m_idx]);
            if (b != int'(m_lvl[m_idx])) begin
                if (room) begin
                    q.push_back(m_idx * 2 + b);
                    m_lvl[m_idx] = b[0];
                    m_idx = (m_idx + 1) % CH;
                end else begin
                    m_stall = 1;
                end
            end else begin
                m_idx = (m_idx + 1) % CH;
            end
        end
        if (!enable_i) m_mode = 0;
        else if (m_mode < 2) m_mode++;
        if (enable_i) begin
            en_cnt++;
            m_dec = (en_cnt % DP == 0);
        end else begin
            en_cnt = 0;
            m_dec  = 0;
        end
    endtask

    task automatic compare_all();
        int h;
        h = (q.size() > 0) ? q[0] : last_ev;
        chk_val("dec", dec_o, m_dec);
        chk_val("valid", ev_valid_o, q.size() > 0);
        chk_val("channel", ev_channel_o, h / 2);
        chk_val("level", ev_level_o, h % 2);
        chk_val("stall", stall_o, m_stall);
        chk_val("state", state_o, m_lvl);
    endtask

    // One clock: called just after a falling edge, returns after the next one
    task automatic tick();
        if (ev_valid_o && ev_ready_i && reset_n) dut_log.push_back(int'(ev_channel_o));
        @(posedge clock);
        if (reset_n) model_step();
        #1;
        compare_all();
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        reset_n = 1'b1;
    endtask

    // Drop enable long enough to return to IDLE, then rescan from channel 0
    task automatic resync(input logic [CH-1:0] lv);
        enable_i = 1'b0;
        tick();
        sensed_i = lv;
        enable_i = 1'b1;
        run(2);
    endtask

    initial begin
        reset_n    = 1'b0;
        enable_i   = 1'b0;
        sensed_i   = '0;
        ev_ready_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk_val("rst_valid", ev_valid_o, 0);
        chk_val("rst_state", state_o, 0);
        @(negedge clock);
        run(2);
        reset_n = 1'b1;
        run(2);

        // Strobe period, disable, re-enable restart
        ev_ready_i = 1'b1;
        enable_i   = 1'b1;
        run(26);
        enable_i = 1'b0;
        run(6);
        enable_i = 1'b1;
        run(12);

        // Levels already high at enable produce no events
        resync(8'h05);
        run(3 * CH);
        chk_val("sync_state", state_o, 8'h05);
        chk_val("sync_noev", ev_valid_o, 0);

        // Single change on channel 3, then back
        sensed_i = 8'h0D;
        run(CH + 2);
        chk_val("single_set", state_o[3], 1);
        sensed_i = 8'h05;
        run(CH + 2);
        chk_val("single_clr", state_o[3], 0);

        // Backpressure: channels 0..5 rise with the consumer stalled
        ev_ready_i = 1'b0;
        resync(8'h00);
        sensed_i = 8'h3F;
        run(CH + 2);
        chk_val("bp_stall", stall_o, 1);
        chk_val("bp_valid", ev_valid_o, 1);
        // Release the consumer while full, channel 6 changes the same cycle
        dut_log.delete();
        sensed_i   = 8'h7F;
        ev_ready_i = 1'b1;
        run(3 * CH);
        chk_val("drain_count", dut_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < dut_log.size()) chk_val("drain_order", dut_log[i], i);
        end

        // Reset in the middle of a scan with events queued
        ev_ready_i = 1'b0;
        resync(8'h00);
        sensed_i = 8'h07;
        run(CH);
        chk_val("pre_rst_valid", ev_valid_o, 1);
        pulse_reset();
        chk_val("mid_rst_valid", ev_valid_o, 0);
        chk_val("mid_rst_state", state_o, 0);
        chk_val("mid_rst_stall", stall_o, 0);
        ev_ready_i = 1'b1;
        run(3 * CH);
        chk_val("resume_state", state_o, 8'h07);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0)
                sensed_i[$urandom_range(0, CH - 1)] = ~sensed_i[$urandom_range(0, CH - 1)];
            if ($urandom_range(0, 3) == 0)
                sensed_i = sensed_i ^ CH'(1 << $urandom_range(0, CH - 1));
            ev_ready_i = (c % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) enable_i = ~enable_i;
            else if (!enable_i && $urandom_range(0, 9) == 0) enable_i = 1'b1;
            if ($urandom_range(0, 799) == 0) pulse_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bringup_sensor_scanner.md
Name: bringup_sensor_scanner

Overview:
Controller for a bank of bringup_sensor instances. It generates the shared periodic decay strobe that drives every sensor's dec_i, and scans the sensed outputs round-robin. Each level change is reported as a {channel, level} event through a small FIFO with a valid/ready handshake. The block sits between the sensor bank and the bringup status/UART reporting logic, so software sees pin activity changes instead of polling raw levels.

Parameters:
CHANNELS, 8, number of sensor channels scanned (2..64)
CH_BITS, $clog2(CHANNELS), width of the channel index
DEC_PERIOD, 1024, clock cycles between decay strobes (>=2)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable_i  in  1  run scanner and decay strobe
dec_o  out  1  one-cycle decay strobe, broadcast to all sensor dec_i
sensed_i  in  CHANNELS  sensed_o of each sensor, bit n = channel n
ev_valid_o  out  1  event available at FIFO head
ev_ready_i  in  1  consumer accepts head event
ev_channel_o  out  CH_BITS  channel of head event
ev_level_o  out  1  new sensed level of head event
stall_o  out  1  sticky: scanner ever stalled on a full FIFO (cleared by reset only)
state_o  out  CHANNELS  last reported level per channel

Behaviour:
- Reset (async, reset_n=0): dec_o=0, ev_valid_o=0, ev_channel_o=0, ev_level_o=0, stall_o=0, state_o=0, prescaler=0, scan index=0, FIFO empty, FSM=IDLE.
- Prescaler counts 0..DEC_PERIOD-1 while enable_i=1. dec_o=1 for exactly the one cycle after the count wraps from DEC_PERIOD-1 to 0, i.e. first pulse DEC_PERIOD cycles after enable rises, then every DEC_PERIOD cycles. With enable_i=0: prescaler held at 0, dec_o=0.
- FSM states:
  - IDLE: enable_i=0. Next state SYNC when enable_i=1.
  - SYNC: one cycle. state_o <= sensed_i, index <= 0, next RUN. Channels already high at enable produce no events.
  - RUN: examine channel `index` once per cycle.
    - If sensed_i[index] == state_o[index]: index advances.
    - If they differ and the FIFO is not full: push {index, sensed_i[index]}, update state_o[index], index advances.
    - If they differ and the FIFO is full: index holds, nothing is pushed, stall_o <= 1. Retry every cycle; no event is lost.
    - Index wraps from CHANNELS-1 to 0. A full sweep takes CHANNELS cycles when no stall occurs.
  - Any state with enable_i=0: next IDLE, taking effect the following cycle. FIFO contents are kept and remain drainable. state_o is held.
- FIFO:
  - Push-to-visible latency is 1 cycle: the event pushed in cycle t gives ev_valid_o=1 in t+1.
  - Pop occurs when ev_valid_o && ev_ready_i.
  - Head outputs are stable while ev_valid_o=1 and ev_ready_i=0.
  - Simultaneous push and pop when full is allowed: "full" for push purposes is evaluated after the same-cycle pop. Occupancy is unchanged and order is preserved.
  - When empty, ev_channel_o/ev_level_o hold their last value.
- Event order is the FIFO push order. A channel that toggles faster than the sweep reports only the level present when it is scanned. Pulses shorter than one sweep may be missed by design; the sensor hysteresis makes this benign.
- Reset asserted mid-operation clears everything immediately, including queued events.

Decomposition:
- Package bringup_pkg:
  - EV_W = CH_BITS+1.
  - FSM state encoding: IDLE=2'd0, SYNC=2'd1, RUN=2'd2.
  - The event field layout: level in bit 0, channel in bits EV_W-1:1.
- Sub-module bringup_event_fifo (parameters WIDTH, DEPTH):
  - Ports: clock, reset_n, push, push_data, full, pop, pop_data, empty.
  - Registered storage; pointers carry one extra wrap bit for the full/empty distinction.
- Top level contains the prescaler, FSM, scan index and state register.

Test Plan:
- Strobe period: reset, enable_i=1, DEC_PERIOD=8 → dec_o pulses at cycles 8,16,24 after enable; enable_i=0 → dec_o stays 0, and re-enable restarts the count from 0.
- Enable sync: sensed_i=8'h05 before enable → no events after 3 full sweeps; state_o=8'h05.
- Single change: after sync, set sensed_i[3]=1 with ev_ready_i=1 → exactly one event {channel 3, level 1} within CHANNELS+2 cycles; state_o[3]=1. Clear it → event {3, 0}.
- Backpressure: ev_ready_i=0, FIFO_DEPTH=4, toggle channels 0..5 high → 4 events queued, stall_o=1, index held on channel 4; set ev_ready_i=1 → events drain in order 0,1,2,3,4,5 with no loss.
- Simultaneous push/pop at full: FIFO full, ev_ready_i=1 on the same cycle channel 6 changes → occupancy stays 4, order is intact, and {6, 1} eventually delivered.
- Reset mid-scan: 3 events queued, pulse reset_n low for 1 cycle → ev_valid_o=0, state_o=0, stall_o=0 immediately; the block resumes via IDLE→SYNC.
